// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: per-stage enable/flush sequencing for a 5-stage RISC-V pipeline covering load-use, EX redirect, data-memory wait and timeout.
// Latency: enables and flushes are combinational from the current state and inputs (Mealy); state and counters update on the next clk edge.
// Backpressure: a data-memory wait freezes every stage, and a wait of MEM_TIMEOUT cycles latches ERROR, which freezes the pipe until reset.
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs1/2   source registers of the IF/ID instruction and their use flags
//   ex_rd, ex_mem_read             destination register of the ID/EX instruction, and whether it is a load
//   ex_pc_sel                      taken branch/jump resolved in EX
//   mem_req, mem_ready             MEM-stage data access request and its completion
//   pc_en .. mem_wb_en             pipeline register load enables
//   if_id_flush, id_ex_flush       insert NOP into IF/ID, insert bubble into ID/EX
//   state, err                     RUN=00 / MEM_WAIT=01 / ERROR=10, sticky timeout flag
//   stall_cnt, flush_cnt           saturating performance counters
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_pc_sel,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic load_use;
    logic mem_stall;
    logic stall_inc;
    logic flush_inc;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                       (id_uses_rs2 && (ex_rd == id_rs2)));

    // A MEM_WAIT cycle with mem_req low is not a stall, so it releases like mem_ready.
    assign mem_stall = mem_req && !mem_ready;

    // State register, wait counter and performance counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic. wait_q counts not-ready cycles already spent; the
    // cycle that finds it at MEM_TIMEOUT-1 and still stalled is the last one.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Output logic. RUN and MEM_WAIT share the priority chain: the MEM_WAIT
    // release cycle is evaluated exactly like a RUN cycle.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        err         = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        // While reset is low the pipeline registers run their own reset, so
        // every enable stays high and no flush or error is asserted.
        if (reset) begin
            if (state_q == ST_ERROR) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                err       = 1'b1;
            end else if (mem_stall) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                stall_inc = 1'b1;
            end else if (ex_pc_sel) begin
                // Both younger instructions are on the wrong path, including
                // any load-use consumer, so no stall is counted here.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_inc   = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID; ID/EX stays enabled so it captures the bubble.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                stall_inc   = 1'b1;
            end
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: self-checking bench for pipeline_hazard_ctrl with directed and random cycles against a behavioural model.
// Latency: one check group per clock cycle, sampled 1 time unit after the falling edge.
// Backpressure: not applicable; inputs are driven freely each cycle.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_pc_sel;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [1:0]       state;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int total;
    int bad;

    // Behavioural model: a count of consecutive not-ready memory cycles, a
    // sticky error bit, and plain integer counters clipped at CNT_MAX.
    int m_not_ready;
    bit m_error;
    int m_stalls;
    int m_flushes;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_pc_sel   (ex_pc_sel),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .state       (state),
        .err         (err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs
    // against the model, then advance the model across the rising edge.
    task automatic go(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic ld, input logic br, input logic mq, input logic my);
        bit       lu;
        bit       ms;
        logic [4:0] exp_en;
        logic [1:0] exp_fl;
        logic       exp_err;
        int         exp_state;
        @(negedge clk);
        reset       = r;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        ex_rd       = rd;
        ex_mem_read = ld;
        ex_pc_sel   = br;
        mem_req     = mq;
        mem_ready   = my;
        #1;
        lu = ld && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        ms = mq && !my;
        exp_en  = 5'b11111;
        exp_fl  = 2'b00;
        exp_err = 1'b0;
        if (r) begin
            if (m_error) begin
                exp_en  = 5'b00000;
                exp_err = 1'b1;
            end else if (ms) begin
                exp_en = 5'b00000;
            end else if (br) begin
                exp_fl = 2'b11;
            end else if (lu) begin
                exp_en = 5'b00111;
                exp_fl = 2'b01;
            end
        end
        exp_state = m_error ? 2 : ((m_not_ready > 0) ? 1 : 0);
        chk("enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, exp_en});
        chk("flushes", {30'd0, if_id_flush, id_ex_flush}, {30'd0, exp_fl});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("state", {30'd0, state}, 32'(exp_state));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
        @(posedge clk);
        if (!r) begin
            m_not_ready = 0;
            m_error     = 1'b0;
            m_stalls    = 0;
            m_flushes   = 0;
        end else if (!m_error) begin
            if (ms) begin
                m_not_ready++;
                if (m_stalls < CNT_MAX) m_stalls++;
                if (m_not_ready == MEM_TIMEOUT) m_error = 1'b1;
            end else begin
                m_not_ready = 0;
                if (br) begin
                    if (m_flushes < CNT_MAX) m_flushes++;
                end else if (lu) begin
                    if (m_stalls < CNT_MAX) m_stalls++;
                end
            end
        end
    endtask

    task automatic idle();
        go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        go(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        m_not_ready   = 0;
        m_error       = 1'b0;
        m_stalls      = 0;
        m_flushes     = 0;
        reset         = 1'b0;
        id_rs1        = '0;
        id_rs2        = '0;
        id_uses_rs1   = 1'b0;
        id_uses_rs2   = 1'b0;
        ex_rd         = '0;
        ex_mem_read   = 1'b0;
        ex_pc_sel     = 1'b0;
        mem_req       = 1'b0;
        mem_ready     = 1'b1;
        // Initial edge with reset low brings the DUT out of its unknown state.
        @(posedge clk);

        // Reset state, then an idle RUN cycle.
        do_reset();
        idle();

        // Load x5 in EX, ID reads rs2=x5: one stall cycle, then the load has moved on.
        go(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        go(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        // Same dependency on x0: no stall.
        go(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        // Matching register but use flag clear: no stall.
        go(1'b1, 5'd9, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // Redirect with a simultaneous load-use: flush wins, stall not counted.
        do_reset();
        go(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        idle();

        // Three not-ready cycles, then ready on the fourth.
        do_reset();
        repeat (3) go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();

        // Timeout into ERROR, inputs toggling while stuck, then reset recovers.
        do_reset();
        repeat (MEM_TIMEOUT) go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        go(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();
        idle();

        // One short of the timeout, then release: no ERROR.
        repeat (MEM_TIMEOUT - 1) go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();

        // Release cycle carries a redirect: flushes with enables high, back to RUN.
        do_reset();
        repeat (2) go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle();

        // mem_req dropping during a wait releases it; release applies load-use.
        repeat (2) go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        go(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // Counter saturation: 20 load-use stalls, then 20 redirects.
        do_reset();
        repeat (20) begin
            go(1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
            idle();
        end
        repeat (20) go(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();

        // Random traffic; small register range so dependencies actually occur.
        do_reset();
        repeat (800) begin
            go(($urandom_range(0, 59) != 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom),
               5'($urandom_range(0, 3)), 1'($urandom),
               ($urandom_range(0, 5) == 0),
               1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Drives per-stage register enables and flushes for three cases: load-use stalls, taken branch/jump redirects from EX, and multi-cycle data-memory waits.
- Sits beside the forwarding unit and main control.
- Adds a memory-wait timeout with a sticky error state, plus saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: consecutive not-ready memory cycles before entering ERROR; legal range ≥2.
- CNT_W, 16: width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_rs1  in  5  rs1 field of the instruction in IF/ID.
- id_rs2  in  5  rs2 field of the instruction in IF/ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register in ID/EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_pc_sel  in  1  taken branch/jump resolved in EX (the PC mux select).
- mem_req  in  1  the MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID load enable.
- id_ex_en  out  1  ID/EX load enable.
- ex_mem_en  out  1  EX/MEM load enable.
- mem_wb_en  out  1  MEM/WB load enable.
- if_id_flush  out  1  load NOP (0x00000013) into IF/ID.
- id_ex_flush  out  1  load bubble (all controls 0) into ID/EX.
- state  out  2  RUN=00, MEM_WAIT=01, ERROR=10.
- err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  stall cycles, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.

Behaviour:
- Outputs are Mealy: combinational from state and inputs. Counters and state are registered.
- Signal definitions:
  - load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
  - mem_stall = mem_req & ~mem_ready.
- Default (RUN, no event): all enables = 1, all flushes = 0, err = 0.
- Priority in RUN and MEM_WAIT: mem_stall > ex_pc_sel > load_use.
- mem_stall freeze:
  - All five enables = 0, flushes = 0.
  - Branch and load_use are ignored that cycle.
  - stall_cnt += 1.
- ex_pc_sel redirect:
  - Enables = 1, if_id_flush = 1, id_ex_flush = 1. Two bubbles; the PC loads the target.
  - flush_cnt += 1.
  - A simultaneous load_use is discarded because it is on the wrong path; stall_cnt is not incremented.
- load_use stall:
  - pc_en = 0, if_id_en = 0, id_ex_flush = 1; ex_mem_en = 1, mem_wb_en = 1.
  - stall_cnt += 1.
  - Lasts exactly 1 cycle, since the load advances to MEM.
- FSM transitions:
  - RUN: mem_stall → MEM_WAIT and wait_cnt <= 1; otherwise stay in RUN.
  - MEM_WAIT, mem_ready = 1: the release cycle applies normal priority evaluation (branch/load_use can act that cycle); next state RUN, wait_cnt <= 0.
  - MEM_WAIT, mem_ready = 0 and wait_cnt == MEM_TIMEOUT−1: next state ERROR.
  - MEM_WAIT, otherwise: wait_cnt += 1.
  - This gives ERROR on the edge ending the MEM_TIMEOUT-th consecutive not-ready cycle.
  - mem_req dropping while in MEM_WAIT is treated as ready (release).
- ERROR:
  - All enables = 0, flushes = 0, err = 1.
  - Counters hold. State is held until reset.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Reset (reset = 0 at a clk edge):
  - state <= RUN, wait_cnt <= 0, stall_cnt <= 0, flush_cnt <= 0.
  - Effective mid-MEM_WAIT or in ERROR.
  - While reset is low, outputs are forced to enables = 1, flushes = 0, err = 0, so the pipeline registers apply their own reset.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5); ID uses rs2=5 → exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Repeat with ex_rd=0 → no stall.
- ex_pc_sel=1 with load_use also true → if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- mem_req=1, mem_ready=0 for 3 cycles, then 1 → 3 freeze cycles (all enables 0), state 01 for 3 cycles, release on the 4th cycle; stall_cnt=3.
- MEM_TIMEOUT=4, mem_ready held 0 → after 4 freeze cycles state=10, err=1; the stall persists with inputs toggling; reset low for one edge → state=00, err=0, counters 0.
- MEM_WAIT release cycle with ex_pc_sel=1 → same cycle shows both flushes=1 and enables=1; next state RUN.
- CNT_W=4, 20 load-use stalls → stall_cnt saturates at 15.
